// File: rtl/spi_temp_pkg.sv
// Shared types and helpers for the SPI temperature scanner.
// Holds the FSM state encoding, width helper and default parameter values.
package spi_temp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int DEF_NCH         = 2;
   localparam int DEF_FRAME_BITS  = 16;
   localparam int DEF_DATA_BITS   = 8;
   localparam int DEF_CLK_DIV     = 2;
   localparam int DEF_CS_SETUP    = 2;
   localparam int DEF_IDLE_CYCLES = 10;

   // Counter/index width for values 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_temp_scanner_if.sv
// Sensor bus and reading output of the SPI temperature scanner.
// DATA_VALID is a one-cycle pulse with no back-pressure; DATA/DATA_CH hold until the next pulse.
interface spi_temp_scanner_if
   import spi_temp_pkg::*;
#(
   parameter int NCH       = DEF_NCH,
   parameter int DATA_BITS = DEF_DATA_BITS
);
   localparam int CHW = clog2_min1(NCH);

   logic                 SCK;
   logic [NCH-1:0]       CS_N;
   logic                 SIO;
   logic [DATA_BITS-1:0] DATA;
   logic [CHW-1:0]       DATA_CH;
   logic                 DATA_VALID;
   logic                 BUSY;

   modport master (
      output SCK, CS_N, DATA, DATA_CH, DATA_VALID, BUSY,
      input  SIO
   );

   modport slave (
      input  SCK, CS_N, DATA, DATA_CH, DATA_VALID, BUSY,
      output SIO
   );
endinterface

// File: rtl/spi_rx_shifter.sv
// SCK generator and MSB-first receive shifter for one frame.
// start_i launches a frame; done_o pulses on the edge that ends the last SCK high phase.
module spi_rx_shifter
   import spi_temp_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int CLK_DIV    = DEF_CLK_DIV
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 sio_i,
   output logic                 done_o,
   output logic                 sck_o,
   output logic [DATA_BITS-1:0] word_o
);
   localparam int DW = clog2_min1(CLK_DIV);
   localparam int BW = clog2_min1(FRAME_BITS + 1);

   logic                 active_q, active_d;
   logic                 sck_q, sck_d;
   logic [DW-1:0]        div_q, div_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] word_q, word_d;
   logic                 done_c;

   always_comb begin
      active_d = active_q;
      sck_d    = sck_q;
      div_d    = div_q;
      bit_d    = bit_q;
      word_d   = word_q;
      done_c   = 1'b0;
      if (start_i) begin
         active_d = 1'b1;
         sck_d    = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         word_d   = '0;
      end else if (active_q) begin
         if (div_q == DW'(CLK_DIV - 1)) begin
            div_d = '0;
            if (!sck_q) begin
               // Rising edge: sample SIO; only the leading DATA_BITS bits are kept.
               sck_d = 1'b1;
               if (bit_q < BW'(DATA_BITS))
                  word_d = (word_q << 1) | DATA_BITS'(sio_i);
            end else begin
               sck_d = 1'b0;
               if (bit_q == BW'(FRAME_BITS - 1)) begin
                  active_d = 1'b0;
                  done_c   = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         sck_q    <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         word_q   <= '0;
      end else begin
         active_q <= active_d;
         sck_q    <= sck_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         word_q   <= word_d;
      end
   end

   assign done_o = done_c;
   assign sck_o  = sck_q;
   assign word_o = word_q;
endmodule

// File: rtl/spi_temp_scanner.sv
// Round-robin multi-channel SPI temperature reader; FSM and channel rotation live here.
// Optional over-threshold alarm outputs are built when SPI_TEMP_ALARM_EN is defined.
module spi_temp_scanner
   import spi_temp_pkg::*;
#(
   parameter int NCH         = DEF_NCH,
   parameter int FRAME_BITS  = DEF_FRAME_BITS,
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int CLK_DIV     = DEF_CLK_DIV,
   parameter int CS_SETUP    = DEF_CS_SETUP,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
   input  logic                 SYSCLK,
   input  logic                 RST,
   input  logic                 ENABLE,
`ifdef SPI_TEMP_ALARM_EN
   input  logic [DATA_BITS-1:0] THRESH,
   output logic [NCH-1:0]       ALARM,
`endif
   output state_e               dbg_state_o,
   spi_temp_scanner_if.master   bus
);
   localparam int CHW = clog2_min1(NCH);
   localparam int CW  = clog2_min1(CS_SETUP);
   localparam int GW  = clog2_min1(IDLE_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [CHW-1:0]       ch_q, ch_d;
   logic [NCH-1:0]       cs_n_q, cs_n_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [CHW-1:0]       data_ch_q, data_ch_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic                 start, done, sck;
   logic [DATA_BITS-1:0] word;

   spi_rx_shifter #(
      .FRAME_BITS (FRAME_BITS),
      .DATA_BITS  (DATA_BITS),
      .CLK_DIV    (CLK_DIV)
   ) u_shifter (
      .clk_i   (SYSCLK),
      .rst_i   (RST),
      .start_i (start),
      .sio_i   (bus.SIO),
      .done_o  (done),
      .sck_o   (sck),
      .word_o  (word)
   );

   // gap_q counts remaining idle cycles; zero means the next frame may start.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      ch_d      = ch_q;
      cs_n_d    = cs_n_q;
      data_d    = data_q;
      data_ch_d = data_ch_q;
      valid_d   = 1'b0;
      start     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (ENABLE) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
               cs_n_d  = ~(NCH'(1) << ch_q);
            end
         end
         ST_SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               state_d = ST_SHIFT;
               start   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (done) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               state_d   = ST_IDLE;
               cs_n_d    = '1;
               data_d    = word;
               data_ch_d = ch_q;
               valid_d   = 1'b1;
               ch_d      = (ch_q == CHW'(NCH - 1)) ? '0 : ch_q + 1'b1;
               gap_d     = GAP_LOAD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = ~&cs_n_d;
   end

   always_ff @(posedge SYSCLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gap_q     <= '0;
         ch_q      <= '0;
         cs_n_q    <= '1;
         data_q    <= '0;
         data_ch_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         ch_q      <= ch_d;
         cs_n_q    <= cs_n_d;
         data_q    <= data_d;
         data_ch_q <= data_ch_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
      end
   end

`ifdef SPI_TEMP_ALARM_EN
   logic [NCH-1:0] alarm_q;

   always_ff @(posedge SYSCLK) begin
      if (RST)
         alarm_q <= '0;
      else if (valid_d)
         alarm_q[ch_q] <= ($signed(word) > $signed(THRESH));
   end

   assign ALARM = alarm_q;
`endif

   assign bus.SCK        = sck;
   assign bus.CS_N       = cs_n_q;
   assign bus.DATA       = data_q;
   assign bus.DATA_CH    = data_ch_q;
   assign bus.DATA_VALID = valid_q;
   assign bus.BUSY       = busy_q;
   assign dbg_state_o    = state_q;
endmodule

// File: doc/spi_temp_scanner.md
Name: spi_temp_scanner

Overview:
- Parametrised, multi-channel SPI temperature-sensor reader.
- Drives one shared SCK and one active-low chip select per sensor, and reads the sensors round-robin.
- Shifts in a configurable frame and keeps the leading DATA_BITS bits as a two's-complement reading.
- Presents each reading as a one-cycle valid pulse tagged with its channel number, for downstream display/BCD logic.

Parameters:
- NCH, 2: number of sensors / chip selects (1..8).
- FRAME_BITS, 16: SCK cycles per frame.
- DATA_BITS, 8: leading (MSB-first) frame bits kept; must be <= FRAME_BITS.
- CLK_DIV, 2: SYSCLK cycles per SCK half-period (>= 1).
- CS_SETUP, 2: SYSCLK cycles between CS_N fall and first SCK rise, and between last SCK fall and CS_N rise.
- IDLE_CYCLES, 10: SYSCLK cycles from CS_N rise to the next CS_N fall.

Ports:
- SYSCLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  scanning enable.
- SIO  in  1  serial data from the sensors.
- SCK  out  1  serial clock; idles low.
- CS_N  out  NCH  per-sensor chip select, active low; at most one bit low at a time.
- DATA  out  DATA_BITS  last captured reading, two's complement.
- DATA_CH  out  clog2(NCH) (min 1)  channel of DATA.
- DATA_VALID  out  1  one-cycle pulse when DATA/DATA_CH update.
- BUSY  out  1  high while any CS_N bit is low.

Behaviour:
- Reset: while RST is high at an edge, the following values apply at that edge.
  - CS_N = all ones; SCK = 0; DATA = 0; DATA_CH = 0; DATA_VALID = 0; BUSY = 0.
  - State = IDLE; gap counter is cleared so the first frame may start immediately; next channel = 0.
  - Reset mid-frame aborts the frame, produces no DATA_VALID, and the next frame targets channel 0.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE: once the gap counter has reached IDLE_CYCLES and ENABLE=1, lower CS_N[ch] and enter SETUP. If ENABLE=0, remain in IDLE.
- SETUP: wait CS_SETUP cycles, then enter SHIFT with SCK low.
- SHIFT: each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
  - SIO is sampled on the SYSCLK edge that drives SCK 0->1.
  - Bits 0..DATA_BITS-1 shift into the shift register MSB-first. Later bits are clocked but discarded.
  - After the FRAME_BITS-th high phase, SCK returns low and the FSM enters HOLD.
- HOLD: wait CS_SETUP cycles. On the edge that raises CS_N:
  - DATA <= shift register, DATA_CH <= ch, DATA_VALID = 1 for that cycle only;
  - ch <= ch+1, wrapping NCH-1 -> 0;
  - gap counter cleared; return to IDLE.
- Timing:
  - CS_N low time per frame = 2*CS_SETUP + 2*CLK_DIV*FRAME_BITS cycles (68 at defaults).
  - Frame period = that + IDLE_CYCLES.
- ENABLE=0 mid-frame does not abort the frame; the frame completes, then the block idles.
- DATA holds its value between pulses; it is never cleared except by RST.
- BUSY equals ~&CS_N, registered.

Optional Feature:
- Macro SPI_TEMP_ALARM_EN.
- When defined, adds:
  - input THRESH [DATA_BITS-1:0], signed;
  - output ALARM [NCH-1:0], reset 0.
- On each DATA_VALID, ALARM[DATA_CH] <= ($signed(new DATA) > $signed(THRESH)). The other ALARM bits are unchanged, and ALARM updates in the same cycle as DATA.
- When undefined, both ports and all compare logic are absent; all other behaviour is identical.

Decomposition:
- Package spi_temp_pkg holds:
  - FSM state enum (IDLE/SETUP/SHIFT/HOLD);
  - clog2 helper for counter and channel widths;
  - default parameter constants.
- Natural sub-module: spi_rx_shifter. It contains the SCK divider, SCK generation, bit counter and DATA_BITS capture register. Interface: start in, done pulse out, SCK out, SIO in, word out.
- The FSM and channel rotation stay in the top level.

Test Plan (defaults: NCH=2, FRAME_BITS=16, DATA_BITS=8, CLK_DIV=2, CS_SETUP=2, IDLE_CYCLES=10):
- RST=1 for 3 cycles, ENABLE=0 -> CS_N=2'b11, SCK=0, DATA=0, DATA_VALID=0, BUSY=0; nothing changes while ENABLE stays 0.
- ENABLE=1, ch0 model returns 0x19 then 8 zero bits -> CS_N[0] low for exactly 68 cycles, 16 SCK rises, one DATA_VALID with DATA=8'h19, DATA_CH=0.
- Continue; ch1 returns 0xE7 -> after a 10-cycle gap CS_N=2'b01, DATA=8'hE7, DATA_CH=1; the third frame selects ch0 again (wrap).
- Drop ENABLE at bit 5 of a frame -> frame completes with a valid pulse; no further CS_N assertion.
- Assert RST during SHIFT bit 5 -> next edge CS_N=2'b11, SCK=0, no DATA_VALID; after release the first frame uses CS_N[0].
- With SPI_TEMP_ALARM_EN and THRESH=8'd30:
  - ch0=0x20 -> ALARM=2'b01;
  - ch1=0xE7 -> ALARM unchanged (signed compare);
  - ch0=0x1E -> ALARM=2'b00.
